pkt_mem_loader: RTL

Upstream neighbour of the IDS stage in the user data path. Forwards every packet unchanged through a one-cycle register stage while snooping for memory-load packets: Ethernet frames with a configured EtherType whose payload carries a start address, a word count and 64-bit data words. Each data word is written into the unified memory through a simple write port, so memory images can be loaded over the network instead of word-by-word through software registers.

---
 rtl/pkt_mem_loader_pkg.sv | 8 +
 rtl/pkt_mem_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pkt_mem_loader_pkg.sv
// pkt_mem_loader_pkg: shared state encoding and load-packet field positions
package pkt_mem_loader_pkg;
  typedef enum logic [2:0] {SKIP, HDR, ETH, LHDR, LDATA} state_e;
  localparam logic [15:0] DEF_LOAD_ETHERTYPE = 16'h88B5;
  localparam int ETYPE_LSB = 16;
  localparam int CNT_LSB = 32;
  localparam int ADDR_LSB = 48;
endpackage

// File: rtl/pkt_mem_loader.sv
// pkt_mem_loader: one-cycle pass-through that snoops load packets and writes their data words to memory
module pkt_mem_loader
  import pkt_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 10,
  parameter logic [15:0] LOAD_ETHERTYPE = DEF_LOAD_ETHERTYPE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  load_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  load_done,
  output logic [31:0]           load_count,
  output logic [31:0]           err_count
);
  state_e st_q, st_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [15:0] n_q, n_d, i_q, i_d, i_nx;
  logic [DATA_WIDTH-1:0] out_data_q, mem_din_q, mem_din_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;
  logic out_wr_q, mem_we_q, mem_we_d, load_done_q, load_done_d;
  logic [31:0] load_count_q, load_count_d, err_count_q, err_count_d;
  logic eop, fin, ok;
  assign in_rdy = out_rdy;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr = out_wr_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign load_done = load_done_q;
  assign load_count = load_count_q;
  assign err_count = err_count_q;
  // next-state: packet parser, memory write generation and completion/error accounting
  always_comb begin
    eop = |in_ctrl;
    i_nx = (i_q < n_q) ? i_q + 16'd1 : i_q;
    st_d = st_q;
    addr_d = addr_q;
    n_d = n_q;
    i_d = i_q;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    fin = 1'b0;
    ok = 1'b0;
    if (in_wr) begin
      case (st_q)
        SKIP: st_d = eop ? HDR : SKIP;
        HDR: st_d = eop ? HDR : ETH;
        ETH: st_d = eop ? HDR : (in_data[ETYPE_LSB +: 16] == LOAD_ETHERTYPE && load_en) ? LHDR : SKIP;
        LHDR: begin
          addr_d = ADDR_WIDTH'(in_data[ADDR_LSB +: 16]);
          n_d = in_data[CNT_LSB +: 16];
          i_d = 16'd0;
          st_d = eop ? HDR : LDATA;
          fin = eop;
          ok = in_data[CNT_LSB +: 16] == 16'd0;
        end
        LDATA: begin
          if (i_q < n_q) begin
            mem_we_d = 1'b1;
            mem_addr_d = addr_q + ADDR_WIDTH'(i_q);
            mem_din_d = in_data;
          end
          i_d = i_nx;
          st_d = eop ? HDR : LDATA;
          fin = eop;
          ok = i_nx >= n_q;
        end
        default: st_d = SKIP;
      endcase
    end
    load_done_d = fin & ok;
    load_count_d = load_count_q + 32'(fin & ok);
    err_count_d = err_count_q + 32'(fin & ~ok);
  end
  // register stage for the forwarded stream, parser state and memory/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= SKIP;
      addr_q <= '0;
      n_q <= '0;
      i_q <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      load_done_q <= 1'b0;
      load_count_q <= '0;
      err_count_q <= '0;
    end else begin
      st_q <= st_d;
      addr_q <= addr_d;
      n_q <= n_d;
      i_q <= i_d;
      out_data_q <= in_data;
      out_ctrl_q <= in_ctrl;
      out_wr_q <= in_wr;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      load_done_q <= load_done_d;
      load_count_q <= load_count_d;
      err_count_q <= err_count_d;
    end
  end
endmodule
